game_over_text_renderer: RTL and testbench

Pixel-pipeline stage that reads the "GAME OVER" text ROM and draws its characters on the VGA stream. From the incoming hcount/vcount it forms the character address `char_yx` for the text ROM and the glyph row `char_line` for the font ROM. It takes the returned 8-pixel glyph row `char_pixels`, overlays foreground pixels on `rgb_in` and re-times all sync and blank signals. It sits between the background/snake drawing stages and the VGA output register.

---
 rtl/game_over_text_renderer.sv | 156 +++++++++++++++
 tb/tb_game_over_text_renderer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/game_over_text_renderer.sv
// rtl/game_over_text_renderer.sv - overlays blinking "GAME OVER" text glyphs onto the VGA pixel stream
module game_over_text_renderer #(
  parameter int          XPOS         = 448,
  parameter int          YPOS         = 376,
  parameter int          TEXT_COLS    = 16,
  parameter int          TEXT_ROWS    = 1,
  parameter logic [11:0] FG_RGB       = 12'hFFF,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_yx,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Box bounds are widened to 12 bits so XPOS + 8*TEXT_COLS cannot wrap.
  localparam logic [11:0] X_LO       = 12'(XPOS);
  localparam logic [11:0] X_HI       = 12'(XPOS + 8 * TEXT_COLS);
  localparam logic [11:0] Y_LO       = 12'(YPOS);
  localparam logic [11:0] Y_HI       = 12'(YPOS + 16 * TEXT_ROWS);
  // Only the low bits of rel_x/rel_y feed the address, so only those are subtracted.
  localparam logic [6:0]  XOFF       = 7'(XPOS);
  localparam logic [7:0]  YOFF       = 8'(YPOS);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  localparam logic [0:0] SHOW = 1'b0;
  localparam logic [0:0] HIDE = 1'b1;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        in_box;
    logic [2:0]  bit_sel;
  } pipe_t;

  logic [6:0]  rel_x;
  logic [7:0]  rel_y;
  logic        frame_start;
  pipe_t       s0;
  pipe_t       s1_q, s2_q, s3_q;
  logic [7:0]  char_yx_q;
  logic [3:0]  line_s1_q, char_line_q;

  logic        en_frame_q, en_frame_d;
  logic [0:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  logic        lit;
  logic [11:0] rgb_d, rgb_q;
  pipe_t       out_q;

  // Stage 0: text-box geometry and glyph addressing from the raw coordinates.
  always_comb begin
    rel_x       = hcount_in[6:0] - XOFF;
    rel_y       = vcount_in[7:0] - YOFF;
    frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);
    s0.hcount   = hcount_in;
    s0.vcount   = vcount_in;
    s0.hsync    = hsync_in;
    s0.vsync    = vsync_in;
    s0.hblnk    = hblnk_in;
    s0.vblnk    = vblnk_in;
    s0.rgb      = rgb_in;
    s0.in_box   = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                  ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
    s0.bit_sel  = ~rel_x[2:0];
  end

  // Frame-latched enable and blink state; both only advance on a frame start.
  always_comb begin
    en_frame_d = en_frame_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (frame_start) en_frame_d = enable;
    if (!en_frame_q || (BLINK_FRAMES == 0)) begin
      state_d = SHOW;
      cnt_d   = 16'd0;
    end else if (frame_start) begin
      if (cnt_q == BLINK_LAST) begin
        cnt_d   = 16'd0;
        state_d = (state_q == SHOW) ? HIDE : SHOW;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Final stage: blanking wins, then lit glyph pixels, otherwise the background.
  always_comb begin
    lit   = en_frame_q && (state_q == SHOW) && s3_q.in_box && char_pixels[s3_q.bit_sel];
    rgb_d = s3_q.rgb;
    if (s3_q.hblnk || s3_q.vblnk) rgb_d = 12'h000;
    else if (lit)                 rgb_d = FG_RGB;
  end

  // Pipeline registers: 4-deep delay, ROM addresses and blink state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      out_q       <= '0;
      rgb_q       <= '0;
      char_yx_q   <= '0;
      line_s1_q   <= '0;
      char_line_q <= '0;
      en_frame_q  <= 1'b0;
      state_q     <= SHOW;
      cnt_q       <= '0;
    end else begin
      s1_q        <= s0;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      out_q       <= s3_q;
      rgb_q       <= rgb_d;
      char_yx_q   <= {rel_y[7:4], rel_x[6:3]};
      line_s1_q   <= rel_y[3:0];
      char_line_q <= line_s1_q;
      en_frame_q  <= en_frame_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign char_yx    = char_yx_q;
  assign char_line  = char_line_q;
  assign hcount_out = out_q.hcount;
  assign vcount_out = out_q.vcount;
  assign hsync_out  = out_q.hsync;
  assign vsync_out  = out_q.vsync;
  assign hblnk_out  = out_q.hblnk;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_game_over_text_renderer.sv
// tb/tb_game_over_text_renderer.sv - self-checking bench for game_over_text_renderer
module tb_game_over_text_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_yx;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int errors = 0;
  int checks = 0;

  game_over_text_renderer #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .char_yx(char_yx), .char_line(char_line), .char_pixels(char_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [7:0]  pix;
    logic [11:0] exp_rgb;
    logic [7:0]  exp_yx;
    logic [3:0]  exp_line;
  } vec_t;

  vec_t vecs[12];
  logic vis_exp[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic [10:0] hc, input logic [10:0] vc, input logic [11:0] rgb,
                         input logic [7:0] pix);
    hcount_in   = hc;
    vcount_in   = vc;
    rgb_in      = rgb;
    char_pixels = pix;
    hblnk_in    = 1'b0;
    vblnk_in    = 1'b0;
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
  endtask

  task automatic frame_start();
    set_pix(11'd0, 11'd0, 12'h000, 8'h00);
    step();
  endtask

  initial begin
    vecs[0]  = '{11'd450, 11'd380, 1'b0, 1'b0, 12'h123, 8'h7C, 12'hFFF, 8'h00, 4'h4};
    vecs[1]  = '{11'd455, 11'd376, 1'b0, 1'b0, 12'h456, 8'h80, 12'h456, 8'h00, 4'h0};
    vecs[2]  = '{11'd455, 11'd376, 1'b0, 1'b0, 12'h456, 8'h01, 12'hFFF, 8'h00, 4'h0};
    vecs[3]  = '{11'd447, 11'd376, 1'b0, 1'b0, 12'h789, 8'hFF, 12'h789, 8'h0F, 4'h0};
    vecs[4]  = '{11'd576, 11'd376, 1'b0, 1'b0, 12'h9AB, 8'hFF, 12'h9AB, 8'h00, 4'h0};
    vecs[5]  = '{11'd575, 11'd391, 1'b0, 1'b0, 12'h321, 8'h01, 12'hFFF, 8'h0F, 4'hF};
    vecs[6]  = '{11'd500, 11'd392, 1'b0, 1'b0, 12'h654, 8'hFF, 12'h654, 8'h16, 4'h0};
    vecs[7]  = '{11'd460, 11'd375, 1'b0, 1'b0, 12'h987, 8'hFF, 12'h987, 8'hF1, 4'hF};
    vecs[8]  = '{11'd450, 11'd380, 1'b1, 1'b0, 12'hABC, 8'hFF, 12'h000, 8'h00, 4'h4};
    vecs[9]  = '{11'd450, 11'd380, 1'b0, 1'b1, 12'hABC, 8'hFF, 12'h000, 8'h00, 4'h4};
    vecs[10] = '{11'd464, 11'd380, 1'b0, 1'b0, 12'h0F0, 8'h20, 12'h0F0, 8'h02, 4'h4};
    vecs[11] = '{11'd471, 11'd383, 1'b0, 1'b0, 12'h00F, 8'h01, 12'hFFF, 8'h02, 4'h7};
    vis_exp  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state with busy inputs
    rst_n  = 1'b0;
    enable = 1'b1;
    set_pix(11'd450, 11'd380, 12'hABC, 8'hFF);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    step();
    step();
    chk("reset_rgb", 32'(rgb_out), 32'h0);
    chk("reset_yx", 32'(char_yx), 32'h0);
    chk("reset_line", 32'(char_line), 32'h0);
    chk("reset_hcount", 32'(hcount_out), 32'h0);
    chk("reset_hsync", 32'(hsync_out), 32'h0);
    rst_n = 1'b1;

    // Text enabled for this frame, blink state SHOW
    frame_start();
    for (int i = 0; i < 12; i++) begin
      set_pix(vecs[i].hc, vecs[i].vc, vecs[i].rgb, vecs[i].pix);
      hblnk_in = vecs[i].hb;
      vblnk_in = vecs[i].vb;
      hsync_in = vecs[i].hc[0];
      repeat (4) step();
      chk($sformatf("vec%0d_rgb", i), 32'(rgb_out), 32'(vecs[i].exp_rgb));
      chk($sformatf("vec%0d_yx", i), 32'(char_yx), 32'(vecs[i].exp_yx));
      chk($sformatf("vec%0d_line", i), 32'(char_line), 32'(vecs[i].exp_line));
      chk($sformatf("vec%0d_hcount", i), 32'(hcount_out), 32'(vecs[i].hc));
      chk($sformatf("vec%0d_vcount", i), 32'(vcount_out), 32'(vecs[i].vc));
      chk($sformatf("vec%0d_hblnk", i), 32'(hblnk_out), 32'(vecs[i].hb));
      chk($sformatf("vec%0d_hsync", i), 32'(hsync_out), 32'(vecs[i].hc[0]));
    end

    // Per-stage latency for a single pixel
    set_pix(11'd600, 11'd390, 12'h111, 8'h00);
    repeat (5) step();
    set_pix(11'd450, 11'd380, 12'h222, 8'h00);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    step();
    chk("lat_yx_t1", 32'(char_yx), 32'h00);
    set_pix(11'd600, 11'd390, 12'h111, 8'h00);
    step();
    chk("lat_line_t2", 32'(char_line), 32'h4);
    step();
    chk("lat_hsync_t3", 32'(hsync_out), 32'h0);
    char_pixels = 8'h7C;
    step();
    chk("lat_rgb_t4", 32'(rgb_out), 32'hFFF);
    chk("lat_hsync_t4", 32'(hsync_out), 32'h1);
    chk("lat_vsync_t4", 32'(vsync_out), 32'h1);
    chk("lat_hcount_t4", 32'(hcount_out), 32'd450);
    char_pixels = 8'h00;
    step();
    chk("lat_rgb_t5", 32'(rgb_out), 32'h111);
    chk("lat_hsync_t5", 32'(hsync_out), 32'h0);

    // Enable low at frame start, rising mid-frame: hidden until next frame
    enable = 1'b0;
    frame_start();
    set_pix(11'd450, 11'd380, 12'h0A0, 8'h7C);
    repeat (5) step();
    chk("en_off_rgb", 32'(rgb_out), 32'h0A0);
    set_pix(11'd450, 11'd100, 12'h0A0, 8'h7C);
    enable = 1'b1;
    step();
    set_pix(11'd450, 11'd380, 12'h0A0, 8'h7C);
    repeat (5) step();
    chk("en_midframe_rgb", 32'(rgb_out), 32'h0A0);

    // Blink with two frames per half-period
    for (int f = 0; f < 6; f++) begin
      frame_start();
      set_pix(11'd450, 11'd380, 12'h0A0, 8'h7C);
      repeat (5) step();
      chk($sformatf("blink_frame%0d", f + 1), 32'(rgb_out), vis_exp[f] ? 32'hFFF : 32'h0A0);
    end

    // Asynchronous reset mid-line
    set_pix(11'd450, 11'd380, 12'h0A0, 8'h7C);
    hsync_in = 1'b1;
    repeat (5) step();
    chk("pre_rst_rgb", 32'(rgb_out), 32'hFFF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", 32'(rgb_out), 32'h0);
    chk("async_rst_hsync", 32'(hsync_out), 32'h0);
    chk("async_rst_hcount", 32'(hcount_out), 32'h0);
    chk("async_rst_yx", 32'(char_yx), 32'h0);
    chk("async_rst_line", 32'(char_line), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_t3_rgb", 32'(rgb_out), 32'h0);
    chk("post_rst_t3_hcount", 32'(hcount_out), 32'h0);
    step();
    chk("post_rst_t4_hcount", 32'(hcount_out), 32'd450);
    chk("post_rst_t4_hsync", 32'(hsync_out), 32'h1);
    chk("post_rst_hidden_rgb", 32'(rgb_out), 32'h0A0);
    frame_start();
    set_pix(11'd450, 11'd380, 12'h0A0, 8'h7C);
    repeat (5) step();
    chk("post_rst_next_frame_rgb", 32'(rgb_out), 32'hFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
